// File: rtl/taylor_pkg.sv
// Shared types and constants for the Taylor-series exp/cosh sequencer.
// The FSM encoding and operand-select codes live here so the datapath can agree on them.
package taylor_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_LOAD,
        ST_MX1_GO,
        ST_MX1_WT,
        ST_MX2_GO,
        ST_MX2_WT,
        ST_MC_GO,
        ST_MC_WT,
        ST_ADD,
        ST_DONE
    } state_t;

    localparam logic MODE_EXP     = 1'b0;
    localparam logic MODE_COSH    = 1'b1;

    localparam logic MUL_SEL_X    = 1'b0;
    localparam logic MUL_SEL_COEF = 1'b1;

endpackage

// File: rtl/taylor_term_cnt.sv
// Term index counter k for the Taylor sequencer.
// Loads 1 on init, steps on inc, and flags when the final term has been reached.
module taylor_term_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             inc,
    input  logic [CNT_W-1:0] n,
    output logic [CNT_W-1:0] k,
    output logic             last
);

    // init wins over inc; the FSM never asserts both in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
        end else if (init) begin
            k <= CNT_W'(1);
        end else if (inc) begin
            k <= k + CNT_W'(1);
        end
    end

    assign last = (k == n);

endmodule

// File: rtl/taylor_seq_ctrl.sv
// Sequencer for the Taylor-series exp/cosh datapath.
// Walks terms 1..n, issuing multiplies via a go/done handshake and accumulating into R.
module taylor_seq_ctrl
    import taylor_pkg::*;
#(
    parameter  int MAX_TERMS = 8,
    localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             mul_done,
    output logic             mul_go,
    output logic             mul_sel,
    output logic             ld_x,
    output logic             init_t,
    output logic             init_r,
    output logic             ld_t,
    output logic             ld_r,
    output logic [CNT_W-1:0] rom_addr,
    output logic             rom_mode,
    output logic             busy,
    output logic             ready,
    output logic             done
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_TERMS);

    state_t           state;
    state_t           next_state;
    logic             mode_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] k;
    logic             k_last;
    logic             cnt_init;
    logic             cnt_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operation parameters are captured only when a new run is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_EXP;
            n_q    <= '0;
        end else if (state == ST_IDLE && start) begin
            mode_q <= mode;
            n_q    <= (n_terms > MAX_N) ? MAX_N : n_terms;
        end
    end

    taylor_term_cnt #(
        .CNT_W (CNT_W)
    ) u_term_cnt (
        .clk  (clk),
        .rst  (rst),
        .init (cnt_init),
        .inc  (cnt_inc),
        .n    (n_q),
        .k    (k),
        .last (k_last)
    );

    // ld_t is the only Mealy output: it follows mul_done in the wait states only
    always_comb begin
        next_state = state;
        mul_go     = 1'b0;
        mul_sel    = MUL_SEL_X;
        ld_x       = 1'b0;
        init_t     = 1'b0;
        init_r     = 1'b0;
        ld_t       = 1'b0;
        ld_r       = 1'b0;
        busy       = 1'b1;
        ready      = 1'b0;
        done       = 1'b0;
        cnt_init   = 1'b0;
        cnt_inc    = 1'b0;

        case (state)
            ST_IDLE: begin
                busy  = 1'b0;
                ready = 1'b1;
                if (start) begin
                    next_state = ST_INIT;
                end
            end
            ST_INIT: begin
                init_t   = 1'b1;
                init_r   = 1'b1;
                cnt_init = 1'b1;
                if (!start) begin
                    next_state = (n_q == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld_x       = 1'b1;
                next_state = ST_MX1_GO;
            end
            ST_MX1_GO: begin
                mul_go     = 1'b1;
                next_state = ST_MX1_WT;
            end
            ST_MX1_WT: begin
                ld_t = mul_done;
                if (mul_done) begin
                    next_state = (mode_q == MODE_COSH) ? ST_MX2_GO : ST_MC_GO;
                end
            end
            ST_MX2_GO: begin
                mul_go     = 1'b1;
                next_state = ST_MX2_WT;
            end
            ST_MX2_WT: begin
                ld_t = mul_done;
                if (mul_done) begin
                    next_state = ST_MC_GO;
                end
            end
            ST_MC_GO: begin
                mul_go     = 1'b1;
                mul_sel    = MUL_SEL_COEF;
                next_state = ST_MC_WT;
            end
            ST_MC_WT: begin
                mul_sel = MUL_SEL_COEF;
                ld_t    = mul_done;
                if (mul_done) begin
                    next_state = ST_ADD;
                end
            end
            ST_ADD: begin
                ld_r = 1'b1;
                if (k_last) begin
                    next_state = ST_DONE;
                end else begin
                    cnt_inc    = 1'b1;
                    next_state = ST_MX1_GO;
                end
            end
            ST_DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                next_state = ST_IDLE;
            end
        endcase
    end

    assign rom_addr = k;
    assign rom_mode = mode_q;

endmodule

// File: tb/tb_taylor_seq_ctrl.sv
// Directed self-checking bench for taylor_seq_ctrl with a variable-latency multiplier model.
// Run latency, handshake counts and operand-select order are checked against hand-derived values.
module tb_taylor_seq_ctrl;

    localparam int MAX_TERMS = 8;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mode;
    logic [CNT_W-1:0] n_terms;
    logic             mul_done;
    logic             mul_go;
    logic             mul_sel;
    logic             ld_x;
    logic             init_t;
    logic             init_r;
    logic             ld_t;
    logic             ld_r;
    logic [CNT_W-1:0] rom_addr;
    logic             rom_mode;
    logic             busy;
    logic             ready;
    logic             done;

    taylor_seq_ctrl #(
        .MAX_TERMS (MAX_TERMS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .n_terms  (n_terms),
        .mul_done (mul_done),
        .mul_go   (mul_go),
        .mul_sel  (mul_sel),
        .ld_x     (ld_x),
        .init_t   (init_t),
        .init_r   (init_r),
        .ld_t     (ld_t),
        .ld_r     (ld_r),
        .rom_addr (rom_addr),
        .rom_mode (rom_mode),
        .busy     (busy),
        .ready    (ready),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    int          resp_delay = 1;
    logic        resp_spur  = 1'b0;
    int          pending    = 0;

    int          go_cnt, ldr_cnt, ldt_cnt, ldx_cnt, done_cnt;
    int          addr_err, mode_err, last_addr, sel_len;
    logic [31:0] sel_pat;
    logic        exp_mode;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Multiplier model: mul_done pulses resp_delay cycles after mul_go, optionally also during the GO cycle
    initial begin
        mul_done = 1'b0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (rst) begin
                pending = 0;
            end else begin
                if (pending > 0) begin
                    pending--;
                    if (pending == 0) mul_done = 1'b1;
                end
                if (mul_go) begin
                    pending = resp_delay;
                    if (resp_spur) mul_done = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mul_go) begin
                if (sel_len < 32) sel_pat[sel_len] = mul_sel;
                sel_len++;
                go_cnt++;
            end
            if (ld_r) begin
                ldr_cnt++;
                if (int'(rom_addr) != ldr_cnt) addr_err++;
                last_addr = int'(rom_addr);
            end
            if (ld_t) ldt_cnt++;
            if (ld_x) ldx_cnt++;
            if (done) done_cnt++;
            if (busy && rom_mode !== exp_mode) mode_err++;
        end
    end

    task automatic clearCounters();
        go_cnt = 0; ldr_cnt = 0; ldt_cnt = 0; ldx_cnt = 0; done_cnt = 0;
        addr_err = 0; mode_err = 0; last_addr = 0; sel_len = 0; sel_pat = '0;
    endtask

    task automatic applyStimulus(input logic m, input int n, input int hold, input int dly,
                                 input logic spur, input logic scramble, output int lat);
        bit got;
        resp_delay = dly;
        resp_spur  = spur;
        @(negedge clk);
        clearCounters();
        exp_mode = m;
        mode     = m;
        n_terms  = n[CNT_W-1:0];
        start    = 1'b1;
        repeat (hold) @(posedge clk);
        #1 start = 1'b0;
        if (scramble) begin
            mode    = ~m;
            n_terms = 4'd1;
        end
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            #2;
            lat++;
            if (done) got = 1'b1;
        end
        if (!got) lat = -1;
        repeat (2) @(negedge clk);
        mode      = 1'b0;
        n_terms   = '0;
        resp_spur = 1'b0;
    endtask

    task automatic verifyRun(input string name, input logic m, input int n, input int dly, input int lat);
        int mults, per, exp_lat;
        logic [31:0] exp_pat;
        mults   = m ? 3 : 2;
        per     = m ? 7 : 5;
        exp_lat = (n == 0) ? 2 : 3 + n * (per + mults * (dly - 1));
        exp_pat = '0;
        for (int i = 0; i < n * mults && i < 32; i++) begin
            exp_pat[i] = m ? (i % 3 == 2) : (i % 2 == 1);
        end
        checkOutput($sformatf("%s.latency", name), lat, exp_lat);
        checkOutput($sformatf("%s.mul_go", name), go_cnt, n * mults);
        checkOutput($sformatf("%s.ld_t", name), ldt_cnt, n * mults);
        checkOutput($sformatf("%s.sel_pattern", name), int'(sel_pat), int'(exp_pat));
        checkOutput($sformatf("%s.ld_r", name), ldr_cnt, n);
        checkOutput($sformatf("%s.last_addr", name), last_addr, n);
        checkOutput($sformatf("%s.addr_order_err", name), addr_err, 0);
        checkOutput($sformatf("%s.ld_x", name), ldx_cnt, (n > 0) ? 1 : 0);
        checkOutput($sformatf("%s.rom_mode_err", name), mode_err, 0);
        checkOutput($sformatf("%s.done_pulses", name), done_cnt, 1);
        checkOutput($sformatf("%s.ready_after", name), int'(ready), 1);
    endtask

    initial begin
        int  lat;
        bit  found;
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        n_terms  = '0;
        exp_mode = 1'b0;
        clearCounters();
        #1;
        checkOutput("reset.ready", int'(ready), 1);
        checkOutput("reset.busy", int'(busy), 0);
        checkOutput("reset.done", int'(done), 0);
        checkOutput("reset.mul_go", int'(mul_go), 0);
        checkOutput("reset.rom_addr", int'(rom_addr), 0);
        checkOutput("reset.init_t", int'(init_t), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 3, 1, 1, 1'b0, 1'b0, lat);
        verifyRun("exp3", 1'b0, 3, 1, lat);

        applyStimulus(1'b1, 2, 1, 1, 1'b0, 1'b0, lat);
        verifyRun("cosh2", 1'b1, 2, 1, lat);

        applyStimulus(1'b0, 0, 1, 1, 1'b0, 1'b0, lat);
        verifyRun("zero", 1'b0, 0, 1, lat);

        applyStimulus(1'b0, 15, 1, 4, 1'b1, 1'b0, lat);
        verifyRun("clamp_stall", 1'b0, MAX_TERMS, 4, lat);

        applyStimulus(1'b0, 4, 5, 1, 1'b0, 1'b1, lat);
        verifyRun("held_start", 1'b0, 4, 1, lat);

        // Abort a cosh run while it is parked in MC_WT
        resp_delay = 6;
        @(negedge clk);
        clearCounters();
        exp_mode = 1'b1;
        mode     = 1'b1;
        n_terms  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            #2;
            if (busy && mul_sel && !mul_go) found = 1'b1;
        end
        checkOutput("abort.reached_mc_wt", int'(found), 1);
        #1 rst = 1'b1;
        exp_mode = 1'b0;
        #1;
        checkOutput("abort.ready", int'(ready), 1);
        checkOutput("abort.busy", int'(busy), 0);
        checkOutput("abort.mul_sel", int'(mul_sel), 0);
        checkOutput("abort.rom_mode", int'(rom_mode), 0);
        checkOutput("abort.rom_addr", int'(rom_addr), 0);
        repeat (3) @(negedge clk);
        checkOutput("abort.no_done", done_cnt, 0);
        rst = 1'b0;

        applyStimulus(1'b0, 2, 1, 1, 1'b0, 1'b0, lat);
        verifyRun("post_abort", 1'b0, 2, 1, lat);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
